// File: rtl/multi_ff_bank_pkg.sv
// Shared constants for the multi-mode flip-flop bank: channel mode encodings.
package ff_bank_pkg;

    localparam int          MODE_W  = 2;
    localparam logic [1:0]  MODE_SR = 2'b00;
    localparam logic [1:0]  MODE_JK = 2'b01;
    localparam logic [1:0]  MODE_D  = 2'b10;
    localparam logic [1:0]  MODE_T  = 2'b11;

endpackage

// File: rtl/ff_cell.sv
// One flip-flop channel: its own mode register, q/qb state and sticky illegal-input flag.
// q_next exposes the combinational next state so the bank can detect changes without extra flops.
module ff_cell
    import ff_bank_pkg::*;
#(
    parameter logic              RESET_Q    = 1'b0,
    parameter logic [MODE_W-1:0] RESET_MODE = MODE_SR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic              en,
    input  logic              a,
    input  logic              b,
    input  logic              illegal_clr,
    output logic              q,
    output logic              qb,
    output logic              illegal,
    output logic              q_next
);

    logic [MODE_W-1:0] mode_q, mode_d;
    logic              q_q, q_d;
    logic              qb_q, qb_d;
    logic              illegal_q, illegal_d;
    logic              illegal_set;

    always_comb begin
        mode_d      = cfg_we ? cfg_mode : mode_q;
        q_d         = q_q;
        illegal_set = 1'b0;
        if (en) begin
            // The mode in force this edge is the registered one; a new cfg_mode only acts next edge.
            case (mode_q)
                MODE_SR: begin
                    case ({a, b})
                        2'b01:   q_d = 1'b0;
                        2'b10:   q_d = 1'b1;
                        2'b11:   illegal_set = 1'b1;
                        default: q_d = q_q;
                    endcase
                end
                MODE_JK: begin
                    case ({a, b})
                        2'b01:   q_d = 1'b0;
                        2'b10:   q_d = 1'b1;
                        2'b11:   q_d = ~q_q;
                        default: q_d = q_q;
                    endcase
                end
                MODE_D:  q_d = a;
                default: q_d = a ? ~q_q : q_q;
            endcase
        end
        qb_d = ~q_d;
        // A fresh illegal event outranks a clear arriving on the same edge.
        if (illegal_set)      illegal_d = 1'b1;
        else if (illegal_clr) illegal_d = 1'b0;
        else                  illegal_d = illegal_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q    <= RESET_MODE;
            q_q       <= RESET_Q;
            qb_q      <= ~RESET_Q;
            illegal_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            q_q       <= q_d;
            qb_q      <= qb_d;
            illegal_q <= illegal_d;
        end
    end

    assign q       = q_q;
    assign qb      = qb_q;
    assign illegal = illegal_q;
    assign q_next  = q_d;

endmodule

// File: rtl/multi_ff_bank.sv
// Bank of WIDTH run-time configurable SR/JK/D/T flip-flops with a sticky illegal flag per channel
// and a saturating count of edges on which any output bit changed.
module multi_ff_bank
    import ff_bank_pkg::*;
#(
    parameter int                WIDTH      = 8,
    parameter int                CNT_W      = 8,
    parameter logic [WIDTH-1:0]  RESET_Q    = {WIDTH{1'b0}},
    parameter logic [MODE_W-1:0] RESET_MODE = MODE_SR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [2*WIDTH-1:0]    cfg_mode,
    input  logic                  en,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic                  illegal_clr,
    input  logic                  cnt_clr,
    output logic [WIDTH-1:0]      q,
    output logic [WIDTH-1:0]      qb,
    output logic [WIDTH-1:0]      illegal,
    output logic                  any_illegal,
    output logic [CNT_W-1:0]      chg_cnt
);

    logic [WIDTH-1:0] q_next;
    logic             q_changed;
    logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) return v;
        return v + 1'b1;
    endfunction

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell #(
            .RESET_Q    (RESET_Q[i]),
            .RESET_MODE (RESET_MODE)
        ) u_cell (
            .clk         (clk),
            .reset       (reset),
            .cfg_we      (cfg_we),
            .cfg_mode    (cfg_mode[MODE_W*i +: MODE_W]),
            .en          (en),
            .a           (a[i]),
            .b           (b[i]),
            .illegal_clr (illegal_clr),
            .q           (q[i]),
            .qb          (qb[i]),
            .illegal     (illegal[i]),
            .q_next      (q_next[i])
        );
    end

    assign q_changed = |(q_next ^ q);

    always_comb begin
        chg_cnt_d = chg_cnt_q;
        if (cnt_clr)        chg_cnt_d = '0;
        else if (q_changed) chg_cnt_d = sat_inc(chg_cnt_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) chg_cnt_q <= '0;
        else        chg_cnt_q <= chg_cnt_d;
    end

    assign chg_cnt     = chg_cnt_q;
    assign any_illegal = |illegal;

endmodule
